sseg_frame_scanner: RTL and testbench
=====================================

// Module: sseg_frame_scanner
// PURPOSE
//  Consumer of the binary-to-BCD converter: accepts a 4-digit BCD word on a load strobe and drives a
//  4-digit common-anode 7-segment display by time-multiplexing the digits.
//  New values are staged and committed only at a frame boundary, so the display never tears mid-scan.
//  Adds anti-ghosting dead time, optional leading-zero blanking and a dash for non-decimal nibbles.
// PARAMETERS
//  REFRESH_DIV  100000  dwell time per digit, in clk cycles (must be >= GHOST_CYC+2)
//  GHOST_CYC    2       cycles at the start of each dwell with all anodes off (must be >= 1)
//  CNT_W        17      width of the dwell counter; must satisfy 2**CNT_W > REFRESH_DIV-1
// PORTS
//  clk          in   1   system clock; single clock domain
//  rst          in   1   synchronous, active-high reset
//  load         in   1   1-cycle strobe: capture bcd_in (connect to converter rdy)
//  bcd_in       in   16  {d3,d2,d1,d0}; d0 = bcd_in[3:0] is the rightmost digit
//  blank_lz     in   1   1 = blank leading zeros (d3..d1); sampled every cycle
//  sseg_a_o     out  4   anodes, active-low; bit k enables digit k
//  sseg_c_o     out  7   cathodes, active-low; bit0=a .. bit6=g
//  pending      out  1   a staged value is waiting for the next frame boundary
//  frame_done   out  1   1-cycle pulse at the end of the digit-3 dwell
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - dwell counter 0, digit index 0, staging reg 0, display reg 0
//   - sseg_a_o=4'b1111, sseg_c_o=7'b1111111, pending=0, frame_done=0
//   - rst takes priority over load; reset mid-scan restarts at digit 0 and discards a staged value.
//  Dwell counter:
//   - counts 0..REFRESH_DIV-1; at REFRESH_DIV-1 it wraps to 0 and the digit index advances 0->1->2->3->0
//   - frame_done=1 on the cycle the counter wraps while the digit index is 3.
//  Load handshake:
//   - load=1 writes bcd_in to the staging reg and sets pending.
//   - A second load before the boundary overwrites the staging reg; the last one wins and none is queued.
//  Commit:
//   - In the cycle frame_done=1, the display reg gets the staging reg if pending, and pending clears.
//   - If load coincides with frame_done, bcd_in is committed directly and pending stays 0.
//  Outputs (all registered; one cycle behind the counter/index state):
//   - counter < GHOST_CYC: sseg_a_o=4'b1111 (dead time)
//   - otherwise: sseg_a_o = ~(4'b0001 << idx)
//   - sseg_c_o encodes display nibble idx.
//  Encoding (gfedcba, active-low):
//   - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
//   - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
//   - nibble 10..15: dash 0111111; blanked digit: 1111111 (anode still driven)
//  Leading-zero blanking (blank_lz=1):
//   - digit k in {3,2,1} is blanked iff digits k..3 are all 0
//   - digit 0 is never blanked (0x0000 shows "   0")
//   - 0xA nibbles count as non-zero.
//  Frame period = 4*REFRESH_DIV cycles. Worst-case load-to-visible latency = 4*REFRESH_DIV+1 cycles.
// TESTING (REFRESH_DIV=4, GHOST_CYC=1 unless noted)
//  1 Reset:
//    - hold rst 3 cycles -> anodes 1111, cathodes 1111111, pending 0.
//    - After release, first frame_done on cycle 16; digit 0 shows 1000000 ("0").
//  2 Load 0x1234 mid-frame:
//    - pending=1 until the next frame_done, then 0.
//    - Next frame shows d0..d3 = 0011001, 0110000, 0100100, 1111001.
//    - Each anode is low for 3 of 4 cycles.
//  3 Two loads:
//    - load 0x1111 then load 0x5678 in the same frame -> next frame shows 5678 only; 1111 never appears.
//  4 Coincident load:
//    - load 0x0042 in the frame_done cycle -> pending stays 0; 42 is displayed from the next frame.
//  5 Leading-zero blanking:
//    - blank_lz=1, 0x0042 -> d3,d2 = 1111111; d1,d0 = 4,2.
//    - 0x0000 -> only d0 lit ("0").
//    - 0x0A05 -> d3 blank, d2 dash, d1 "0".
//  6 Reset mid-operation:
//    - assert rst during the digit-2 dwell with pending=1 -> pending clears, scan restarts at digit 0.
//    - The display reg is 0; the staged value is never shown.

Source files
------------

// File: rtl/sseg_frame_scanner.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with frame-aligned commit,
// anti-ghosting dead time, optional leading-zero blanking and a dash for non-decimal nibbles.
module sseg_frame_scanner #(
    parameter int REFRESH_DIV = 100000,
    parameter int GHOST_CYC   = 2,
    parameter int CNT_W       = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] bcd_in,
    input  logic        blank_lz,
    output logic [3:0]  sseg_a_o,
    output logic [6:0]  sseg_c_o,
    output logic        pending,
    output logic        frame_done
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GHOST = CNT_W'(GHOST_CYC);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [15:0]      stage_q;
    logic [15:0]      disp_q;
    logic             wrap;
    logic [3:0]       nib;
    logic             blank;
    logic             zero_3, zero_32, zero_321;
    logic [3:0]       anode_next;
    logic [6:0]       cath_next;

    function automatic logic [6:0] seg_encode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    always_comb begin
        wrap       = (cnt == CNT_LAST);
        frame_done = wrap && (idx == 2'd3);
    end

    // A digit is a leading zero only if it and every more significant digit are zero.
    always_comb begin
        zero_3   = (disp_q[15:12] == 4'd0);
        zero_32  = zero_3 && (disp_q[11:8] == 4'd0);
        zero_321 = zero_32 && (disp_q[7:4] == 4'd0);
        nib      = disp_q[3:0];
        blank    = 1'b0;
        case (idx)
            2'd0: nib = disp_q[3:0];
            2'd1: begin
                nib   = disp_q[7:4];
                blank = blank_lz && zero_321;
            end
            2'd2: begin
                nib   = disp_q[11:8];
                blank = blank_lz && zero_32;
            end
            default: begin
                nib   = disp_q[15:12];
                blank = blank_lz && zero_3;
            end
        endcase
        cath_next  = blank ? 7'b1111111 : seg_encode(nib);
        anode_next = (cnt < CNT_GHOST) ? 4'b1111 : ~(4'b0001 << idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (wrap) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Staged values only reach the display register at a frame boundary; a load landing
    // exactly on the boundary bypasses the staging register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= 16'h0000;
            disp_q  <= 16'h0000;
            pending <= 1'b0;
        end else if (frame_done) begin
            if (load) begin
                disp_q <= bcd_in;
            end else if (pending) begin
                disp_q <= stage_q;
            end
            pending <= 1'b0;
        end else if (load) begin
            stage_q <= bcd_in;
            pending <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sseg_a_o <= 4'b1111;
            sseg_c_o <= 7'b1111111;
        end else begin
            sseg_a_o <= anode_next;
            sseg_c_o <= cath_next;
        end
    end

endmodule

// File: tb/tb_sseg_frame_scanner.sv
// Directed bench for sseg_frame_scanner with a 4-cycle dwell and 1-cycle dead time.
module tb_sseg_frame_scanner;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] bcd_in;
    logic        blank_lz;
    logic [3:0]  sseg_a_o;
    logic [6:0]  sseg_c_o;
    logic        pending;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] value;
        logic        blz;
        logic [27:0] cath;
    } vec_t;

    vec_t vecs[8];

    localparam logic [27:0] ALL_ZERO = {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
    localparam logic [27:0] SHOW_5678 = {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000};
    localparam logic [27:0] SHOW_0042 = {7'b1000000, 7'b1000000, 7'b0011001, 7'b0100100};

    sseg_frame_scanner #(
        .REFRESH_DIV(4),
        .GHOST_CYC  (1),
        .CNT_W      (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .bcd_in    (bcd_in),
        .blank_lz  (blank_lz),
        .sseg_a_o  (sseg_a_o),
        .sseg_c_o  (sseg_c_o),
        .pending   (pending),
        .frame_done(frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] value, input logic blz);
        bcd_in   = value;
        blank_lz = blz;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    // Leaves the bench at the negedge of the cycle in which frame_done is high.
    task automatic waitFrame(input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) checkOutput({name, "_frame_timeout"}, 32'd0, 32'd1);
    endtask

    // Counts cycles from the first post-reset cycle (cycle 1) to the first frame_done.
    task automatic countToFrame(input string name);
        int n = 1;
        while (!frame_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_frame_cycle"}, 32'(n), 32'd16);
    endtask

    // Called in the first cycle after a commit edge; walks one full frame of outputs.
    task automatic checkFrame(input logic [27:0] exp_cath, input string tag);
        logic [3:0] exp_an;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                exp_an = (j == 0) ? 4'b1111 : ~(4'b0001 << k);
                checkOutput($sformatf("%s_an_d%0d_c%0d", tag, k, j), 32'(sseg_a_o), 32'(exp_an));
                if (j == 1)
                    checkOutput($sformatf("%s_cath_d%0d", tag, k), 32'(sseg_c_o), 32'(exp_cath[k*7 +: 7]));
            end
        end
    endtask

    initial begin
        vecs[0] = '{16'h1234, 1'b0, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
        vecs[1] = '{16'h0042, 1'b1, {7'b1111111, 7'b1111111, 7'b0011001, 7'b0100100}};
        vecs[2] = '{16'h0000, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}};
        vecs[3] = '{16'h0A05, 1'b1, {7'b1111111, 7'b0111111, 7'b1000000, 7'b0010010}};
        vecs[4] = '{16'h0042, 1'b0, SHOW_0042};
        vecs[5] = '{16'hFB98, 1'b0, {7'b0111111, 7'b0111111, 7'b0010000, 7'b0000000}};
        vecs[6] = '{16'h7000, 1'b1, {7'b1111000, 7'b1000000, 7'b1000000, 7'b1000000}};
        vecs[7] = '{16'h0106, 1'b1, {7'b1111111, 7'b1111001, 7'b1000000, 7'b0000010}};

        rst      = 1'b1;
        load     = 1'b0;
        bcd_in   = 16'h0000;
        blank_lz = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset_anodes", 32'(sseg_a_o), 32'hF);
        checkOutput("reset_cathodes", 32'(sseg_c_o), 32'h7F);
        checkOutput("reset_pending", 32'(pending), 32'd0);
        checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
        rst = 1'b0;

        countToFrame("reset");
        @(negedge clk);
        checkFrame(ALL_ZERO, "reset_show");

        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].value, vecs[v].blz);
            checkOutput($sformatf("vec%0d_pending_set", v), 32'(pending), 32'd1);
            waitFrame($sformatf("vec%0d", v));
            checkOutput($sformatf("vec%0d_pending_hold", v), 32'(pending), 32'd1);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_pending_clr", v), 32'(pending), 32'd0);
            checkFrame(vecs[v].cath, $sformatf("vec%0d", v));
        end

        $display("[TB] two loads in one frame, last one wins");
        applyStimulus(16'h1111, 1'b0);
        repeat (3) @(negedge clk);
        applyStimulus(16'h5678, 1'b0);
        waitFrame("twoload");
        @(negedge clk);
        checkOutput("twoload_pending_clr", 32'(pending), 32'd0);
        checkFrame(SHOW_5678, "twoload");

        $display("[TB] load coincident with frame_done");
        waitFrame("coinc");
        applyStimulus(16'h0042, 1'b0);
        checkOutput("coinc_pending", 32'(pending), 32'd0);
        checkFrame(SHOW_0042, "coinc");

        $display("[TB] reset during digit-2 dwell with a staged value");
        applyStimulus(16'h9999, 1'b0);
        repeat (8) @(negedge clk);
        checkOutput("midrst_pending_before", 32'(pending), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_pending", 32'(pending), 32'd0);
        checkOutput("midrst_anodes", 32'(sseg_a_o), 32'hF);
        checkOutput("midrst_cathodes", 32'(sseg_c_o), 32'h7F);
        countToFrame("midrst");
        checkOutput("midrst_pending_frame", 32'(pending), 32'd0);
        @(negedge clk);
        checkFrame(ALL_ZERO, "midrst_show");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
